// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program-counter fetch sequencer between word RAM and decoder
// Reads one word per FETCH, holds it under valid/ready, handles jump redirects and bad-target halt.
module fetch_unit #(
    parameter int address_bus_width = 16,
    parameter int bus_width         = 16,
    parameter int memory_size       = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [bus_width-1:0]         bus,
    output logic [address_bus_width-1:0] address,
    output logic                         rd,
    output logic [bus_width-1:0]         instr,
    output logic [address_bus_width-1:0] instr_addr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         jump_valid,
    input  logic [address_bus_width-1:0] jump_addr,
    output logic                         fault,
    output logic [15:0]                  fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    localparam logic [address_bus_width-1:0] LAST_ADDR = address_bus_width'(memory_size - 1);

    state_t                         state_q, state_d;
    logic [address_bus_width-1:0]   pc_q, pc_d;
    logic [bus_width-1:0]           instr_q, instr_d;
    logic [address_bus_width-1:0]   instr_addr_q, instr_addr_d;
    logic                           instr_valid_q, instr_valid_d;
    logic                           fault_q, fault_d;
    logic [15:0]                    fetch_count_q, fetch_count_d;
    logic                           rd_q, rd_d;
    logic [address_bus_width-1:0]   next_pc;

    assign next_pc = (pc_q == LAST_ADDR) ? '0 : pc_q + address_bus_width'(1);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                instr_d       = bus;
                instr_addr_d  = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = next_pc;
                state_d       = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
                    state_d = run ? FETCH : IDLE;
                end
            end
            default: ;
        endcase

        // A redirect wins over both the capture and the handshake on the same edge.
        if (jump_valid && state_q != HALT) begin
            instr_d       = instr_q;
            instr_addr_d  = instr_addr_q;
            instr_valid_d = 1'b0;
            fetch_count_d = fetch_count_q;
            if (jump_addr <= LAST_ADDR) begin
                pc_d    = jump_addr;
                state_d = run ? FETCH : IDLE;
            end else begin
                pc_d    = pc_q;
                fault_d = 1'b1;
                state_d = HALT;
            end
        end

        rd_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
            rd_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
            rd_q          <= rd_d;
        end
    end

    assign address     = pc_q;
    assign rd          = rd_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a modelled 12-word RAM
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] bus;
    logic [15:0] address;
    logic        rd;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_valid;
    logic [15:0] jump_addr;
    logic        fault;
    logic [15:0] fetch_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        logic        ready;
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [15:0] exp_addr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    fetch_unit #(
        .address_bus_width(16),
        .bus_width(16),
        .memory_size(12)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .bus(bus),
        .address(address),
        .rd(rd),
        .instr(instr),
        .instr_addr(instr_addr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_valid(jump_valid),
        .jump_addr(jump_addr),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    // RAM word[i] = 0x1000 + i, read combinationally
    assign bus = (address < 16'd12) ? (16'h1000 + address) : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Inputs change only at negedge, so this sees the values the next posedge will use.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && instr_valid && instr_ready && !jump_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", sb_q.size(), 1);
            end else begin
                chk("sb_word", {instr_addr, instr}, sb_q.pop_front());
            end
        end
    end

    task automatic push_word(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        sb_q.push_back({a16, 16'h1000 + a16});
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", sb_q.size(), 0);
        sb_q.delete();
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h1000, 16'd1, 16'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h1000, 16'd1, 16'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h1001, 16'd2, 16'd1};

        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        #1;
        chk("rst_address", address, 0);
        chk("rst_rd", rd, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", fetch_count, 0);

        // Streaming with ready high: 13 words including the wrap back to address 0
        @(negedge clk);
        rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 13; i++) push_word(i % 12);
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            chk($sformatf("stream_rd_%0d", cyc), rd, cyc % 2);
            if (cyc == 26) run = 1'b0;
        end
        @(negedge clk);
        chk("stream_count", fetch_count, 13);
        chk("stream_idle_rd", rd, 0);
        chk("stream_idle_valid", instr_valid, 0);
        chk("stream_idle_addr", address, 1);

        // Backpressure, table driven
        do_reset();
        push_word(0);
        for (int i = 0; i < 9; i++) begin
            run = 1'b1;
            instr_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("bp_rd_%0d", i), rd, vecs[i].exp_rd);
            chk($sformatf("bp_valid_%0d", i), instr_valid, vecs[i].exp_valid);
            chk($sformatf("bp_instr_%0d", i), instr, vecs[i].exp_instr);
            chk($sformatf("bp_addr_%0d", i), address, vecs[i].exp_addr);
            chk($sformatf("bp_cnt_%0d", i), fetch_count, vecs[i].exp_cnt);
        end

        // Redirect to 7 on the same edge as a handshake of word 1
        jump_valid = 1'b1; jump_addr = 16'd7; instr_ready = 1'b1;
        @(negedge clk);
        jump_valid = 1'b0;
        chk("jmp_valid_dropped", instr_valid, 0);
        chk("jmp_count_kept", fetch_count, 1);
        chk("jmp_rd", rd, 1);
        chk("jmp_addr", address, 7);
        push_word(7); push_word(8); push_word(9);
        @(negedge clk);
        chk("jmp_first_addr", instr_addr, 7);
        chk("jmp_first_instr", instr, 16'h1007);
        @(negedge clk);
        @(negedge clk);
        chk("jmp_second_instr", instr, 16'h1008);
        @(negedge clk);
        chk("jmp_count3", fetch_count, 3);
        chk("run0_fetch_rd", rd, 1);
        run = 1'b0;
        @(negedge clk);
        chk("run0_delivered_valid", instr_valid, 1);
        chk("run0_delivered_instr", instr, 16'h1009);
        @(negedge clk);
        chk("run0_idle_rd", rd, 0);
        chk("run0_idle_count", fetch_count, 4);
        @(negedge clk);
        chk("run0_idle_rd2", rd, 0);
        chk("run0_idle_addr", address, 10);
        run = 1'b1;
        push_word(10);
        @(negedge clk);
        chk("resume_rd", rd, 1);
        @(negedge clk);
        chk("resume_instr", instr, 16'h100A);
        @(negedge clk);
        chk("resume_count", fetch_count, 5);

        // Out-of-range target from FETCH at pc 11
        jump_valid = 1'b1; jump_addr = 16'd12;
        @(negedge clk);
        chk("bad_fault", fault, 1);
        chk("bad_rd", rd, 0);
        chk("bad_valid", instr_valid, 0);
        chk("bad_pc_kept", address, 11);
        chk("bad_count", fetch_count, 5);
        for (int i = 0; i < 4; i++) begin
            jump_valid = 1'b1; jump_addr = 16'd3; run = i[0]; instr_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("halt_fault_%0d", i), fault, 1);
            chk($sformatf("halt_rd_%0d", i), rd, 0);
            chk($sformatf("halt_addr_%0d", i), address, 11);
        end
        jump_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("halt_rst_fault", fault, 0);
        chk("halt_rst_addr", address, 0);

        // Asynchronous reset while a word is held
        do_reset();
        run = 1'b1; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_hold_valid", instr_valid, 1);
        chk("mid_hold_instr", instr, 16'h1000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_instr", instr, 0);
        chk("async_instr_addr", instr_addr, 0);
        chk("async_address", address, 0);
        chk("async_rd", rd, 0);

        // Jump to the last legal address from IDLE, then wrap
        do_reset();
        jump_valid = 1'b1; jump_addr = 16'd11; run = 1'b1; instr_ready = 1'b1;
        push_word(11); push_word(0);
        @(negedge clk);
        jump_valid = 1'b0;
        chk("last_jmp_addr", address, 11);
        chk("last_jmp_fault", fault, 0);
        @(negedge clk);
        @(negedge clk);
        chk("last_wrap_addr", address, 0);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("last_count", fetch_count, 2);
        chk("last_idle_addr", address, 1);
        chk("last_idle_rd", rd, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction/data fetch sequencer that sits directly upstream of the word RAM. It owns the program counter, drives the RAM address and rd strobe, and captures the word the RAM places on the shared bus into a one-entry output register. It then hands the word to the downstream decoder over a valid/ready handshake. It also supports taken-jump redirects and flags out-of-range targets.

Parameters:
address_bus_width, 16, width of address, pc, jump_addr and instr_addr
bus_width, 16, width of the RAM data bus and the instr output
memory_size, 12, number of RAM words; legal addresses are 0..memory_size-1

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
run  input  1  level enable; fetching proceeds only while 1
bus  input  bus_width  RAM read data (RAM drives it; this block never drives it)
address  output  address_bus_width  RAM word address
rd  output  1  RAM read strobe
instr  output  bus_width  captured word
instr_addr  output  address_bus_width  address the captured word came from
instr_valid  output  1  instr/instr_addr hold a word not yet accepted
instr_ready  input  1  downstream accepts the word when high together with instr_valid at a clk edge
jump_valid  input  1  one-cycle redirect request
jump_addr  input  address_bus_width  redirect target
fault  output  1  sticky; set on an out-of-range jump target
fetch_count  output  16  number of accepted handshakes, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, pc=0, instr=0, instr_addr=0, instr_valid=0, fault=0, fetch_count=0. Outputs: address=0, rd=0. Deassertion takes effect at the next clk edge. Reset asserted mid-operation discards any held word immediately.
- States: IDLE, FETCH, HOLD, HALT. address=pc in every state. rd=1 only in FETCH. Both are decoded from registered state.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: the RAM read is combinational, so bus is valid in the same cycle. At the edge: instr<=bus, instr_addr<=pc, instr_valid<=1, pc<=next(pc), state<=HOLD.
- Latency: 1 cycle from entering FETCH to instr_valid=1. Throughput is 1 word per 2 cycles when instr_ready is held high.
- next(pc) is pc+1, except pc=memory_size-1, which wraps to 0.
- HOLD: instr_valid=1, and instr/instr_addr are held stable while instr_ready=0.
  - Edge with instr_ready=1: instr_valid<=0 and fetch_count increments (saturates at 0xFFFF).
  - Next state after acceptance: FETCH if run=1, else IDLE.
- run=0 during FETCH: that fetch still completes into HOLD. run is only sampled at IDLE, and at HOLD after acceptance.
- Redirect (jump_valid=1 at an edge, in IDLE, FETCH or HOLD): highest priority; it overrides the capture and the handshake on that edge.
  - instr_valid<=0. A word being handshaked on that same edge is NOT counted.
  - If jump_addr<memory_size: pc<=jump_addr, then state<=FETCH if run=1, else IDLE.
  - If jump_addr>=memory_size: fault<=1, state<=HALT, pc unchanged.
- HALT: rd=0 and instr_valid=0. All inputs, including jump_valid, are ignored. Only rst_n exits HALT.
- fault stays at 1 until reset.
- instr_valid never drops without either a handshake, a redirect or a reset.
- pc is never reported outside 0..memory_size-1.

Test Plan:
- Reset, then run=1, instr_ready=1, with RAM word[i]=0x1000+i → rd pulses on alternate cycles. Output sequence (instr_addr/instr) is 0/0x1000, 1/0x1001, … 11/0x100B, 0/0x1000. fetch_count=13 after 13 accepts.
- Backpressure: instr_ready=0 for 5 cycles after the first capture → instr=0x1000 and instr_valid=1 stay stable, rd stays 0 and pc=1. On the ready edge, fetch_count=1, and the next capture is 0x1001.
- Redirect: jump_valid=1, jump_addr=7 in HOLD with instr_ready=1 on the same edge → the held word is dropped and fetch_count is unchanged. The next output is instr_addr=7, instr=0x1007, followed by 8/0x1008.
- Bad target: jump_addr=12 → fault=1, state HALT, rd=0. A later jump_valid with jump_addr=3 and run toggling has no effect. Asserting rst_n=0 clears fault and pc to 0.
- Reset mid-HOLD: rst_n low asynchronously between edges → instr_valid, instr and address go to 0 immediately, without waiting for a clock edge.
- run=0 asserted during FETCH → the word is still delivered. After acceptance the block sits in IDLE with rd=0. Setting run=1 resumes at the next sequential address.
